nxn_crossbar_ctrl: RTL and testbench

- Control end of the single NxN crossbar: it arbitrates among input ports, drives the crossbar's input-select and output-select, and generates the pop and push strobes.
- Grants one packet (multi-flit, tail-terminated) at a time, with round-robin fairness.
- Holds the crossbar path locked from head flit to tail flit.
- Sits in the switch between the input buffers, the crossbar and the output registers.

---
 rtl/nxn_crossbar_ctrl.sv | 131 +++++++++++++
 tb/tb_nxn_crossbar_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/nxn_crossbar_ctrl.sv
// ============================================================================
// Module   : nxn_crossbar_ctrl
// Brief    : Round-robin packet arbiter and path lock for an NxN crossbar.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nxn_crossbar_ctrl #(
    parameter  int PORT_N = 5,
    localparam int SEL_W  = $clog2(PORT_N)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [PORT_N-1:0]       valid_i,
    input  logic [PORT_N-1:0]       last_i,
    input  logic [PORT_N*SEL_W-1:0] dst_i,
    input  logic [PORT_N-1:0]       out_rdy_i,
    output logic [SEL_W-1:0]        in_sel_o,
    output logic [SEL_W-1:0]        out_sel_o,
    output logic                    busy_o,
    output logic                    xfer_o,
    output logic [PORT_N-1:0]       in_ack_o,
    output logic [PORT_N-1:0]       out_vld_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [SEL_W:0]   c_port_n   = (SEL_W+1)'(PORT_N);
    localparam logic [SEL_W-1:0] c_rr_reset = SEL_W'(PORT_N - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   in_sel_q, in_sel_d;
    logic [SEL_W-1:0]   out_sel_q, out_sel_d;
    logic [SEL_W-1:0]   rr_q, rr_d;
    logic               busy_q, busy_d;

    logic [PORT_N-1:0]  w_elig;
    logic               w_found;
    logic [SEL_W-1:0]   w_grant;
    logic [SEL_W-1:0]   w_grant_dst;
    int                 w_idx;
    logic               w_xfer;

    // A destination outside the port range is treated as if the input were idle.
    for (genvar k = 0; k < PORT_N; k++) begin : g_elig
        assign w_elig[k] = valid_i[k] && ({1'b0, dst_i[SEL_W*k +: SEL_W]} < c_port_n);
    end

    always_comb begin
        w_found     = 1'b0;
        w_grant     = '0;
        w_grant_dst = '0;
        w_idx       = 0;
        for (int i = 1; i <= PORT_N; i++) begin
            w_idx = (int'(rr_q) + i) % PORT_N;
            if (!w_found && w_elig[w_idx]) begin
                w_found     = 1'b1;
                w_grant     = SEL_W'(w_idx);
                w_grant_dst = dst_i[SEL_W*w_idx +: SEL_W];
            end
        end
    end

    assign w_xfer = (state_q == BUSY) && valid_i[in_sel_q] && out_rdy_i[out_sel_q];

    always_comb begin
        state_d   = state_q;
        in_sel_d  = in_sel_q;
        out_sel_d = out_sel_q;
        rr_d      = rr_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (w_found) begin
                    state_d   = BUSY;
                    busy_d    = 1'b1;
                    in_sel_d  = w_grant;
                    out_sel_d = w_grant_dst;
                end
            end
            BUSY: begin
                // Selectors stay put on release so the output mux does not glitch.
                if (w_xfer && last_i[in_sel_q]) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    rr_d    = in_sel_q;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        in_ack_o  = '0;
        out_vld_o = '0;
        if (w_xfer) begin
            in_ack_o[in_sel_q]   = 1'b1;
            out_vld_o[out_sel_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            in_sel_q  <= '0;
            out_sel_q <= '0;
            rr_q      <= c_rr_reset;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_sel_q  <= in_sel_d;
            out_sel_q <= out_sel_d;
            rr_q      <= rr_d;
            busy_q    <= busy_d;
        end
    end

    assign in_sel_o  = in_sel_q;
    assign out_sel_o = out_sel_q;
    assign busy_o    = busy_q;
    assign xfer_o    = w_xfer;

endmodule

`default_nettype wire

// File: tb/tb_nxn_crossbar_ctrl.sv
// ============================================================================
// Module   : tb_nxn_crossbar_ctrl
// Brief    : Directed and random checks of nxn_crossbar_ctrl against a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nxn_crossbar_ctrl;

    localparam int N  = 5;
    localparam int SW = 3;

    logic            clk;
    logic            rst;
    logic [N-1:0]    valid, last, rdy;
    logic [N*SW-1:0] dst;
    logic [SW-1:0]   in_sel_o, out_sel_o;
    logic            busy_o, xfer_o;
    logic [N-1:0]    in_ack_o, out_vld_o;

    nxn_crossbar_ctrl #(.PORT_N(N)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (valid),
        .last_i    (last),
        .dst_i     (dst),
        .out_rdy_i (rdy),
        .in_sel_o  (in_sel_o),
        .out_sel_o (out_sel_o),
        .busy_o    (busy_o),
        .xfer_o    (xfer_o),
        .in_ack_o  (in_ack_o),
        .out_vld_o (out_vld_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: which packet (if any) owns the crossbar and where the search resumes.
    bit m_init = 0;
    int m_busy, m_in, m_out, m_rr;
    int m_sent [N];
    int grants [$];
    int obs_xfer;
    int obs_xfer_in [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int dst_of(input int k);
        return int'((dst >> (SW*k)) & 7);
    endfunction

    task automatic set_dst(input int k, input int v);
        dst[SW*k +: SW] = SW'(v);
    endtask

    function automatic int grant_at(input int i);
        return (i < grants.size()) ? grants[i] : -1;
    endfunction

    task automatic clear_counts();
        obs_xfer = 0;
        grants.delete();
        for (int k = 0; k < N; k++) begin
            m_sent[k]      = 0;
            obs_xfer_in[k] = 0;
        end
    endtask

    task automatic step();
        int e_xfer;
        int nb, ni, no, nr, p;
        e_xfer = 0;
        @(negedge clk);
        if (m_init) begin
            e_xfer = (m_busy != 0 && valid[m_in] && rdy[m_out]) ? 1 : 0;
            check("busy",    32'(busy_o),    32'(m_busy));
            check("in_sel",  32'(in_sel_o),  32'(m_in));
            check("out_sel", 32'(out_sel_o), 32'(m_out));
            check("xfer",    32'(xfer_o),    32'(e_xfer));
            check("in_ack",  32'(in_ack_o),  32'(e_xfer << m_in));
            check("out_vld", 32'(out_vld_o), 32'(e_xfer << m_out));
            if (e_xfer != 0) m_sent[m_in]++;
        end
        if (xfer_o === 1'b1) begin
            obs_xfer++;
            if (int'(in_sel_o) < N) obs_xfer_in[in_sel_o]++;
        end
        nb = m_busy; ni = m_in; no = m_out; nr = m_rr;
        if (rst) begin
            nb = 0; ni = 0; no = 0; nr = N - 1;
        end else if (m_init) begin
            if (m_busy == 0) begin
                for (int i = 1; i <= N; i++) begin
                    p = (m_rr + i) % N;
                    if (nb == 0 && valid[p] && dst_of(p) < N) begin
                        nb = 1; ni = p; no = dst_of(p);
                        grants.push_back(p);
                    end
                end
            end else if (e_xfer != 0 && last[m_in]) begin
                nb = 0; nr = m_in;
            end
        end
        @(posedge clk);
        if (rst) m_init = 1;
        m_busy = nb; m_in = ni; m_out = no; m_rr = nr;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_counts();
    endtask

    initial begin
        int exp_order [6];
        int n;
        exp_order = '{0, 1, 2, 3, 4, 0};
        valid = '0; last = '0; rdy = '0; dst = '0; rst = 1'b0;
        clear_counts();
        #1;
        do_reset();

        // Single-flit packet from input 0 to output 3.
        valid = 5'b00001; last = 5'b00001; rdy = '1; set_dst(0, 3);
        step();
        check("s1_grant_cycle_no_xfer", 32'(obs_xfer), 32'd0);
        step();
        valid = '0;
        step();
        check("s1_xfer_count", 32'(obs_xfer), 32'd1);
        check("s1_grant", 32'(grant_at(0)), 32'd0);

        // Round-robin fairness with all ports contending for output 4.
        do_reset();
        valid = '1; last = '1; rdy = '1;
        for (int k = 0; k < N; k++) set_dst(k, 4);
        repeat (12) step();
        check("rr_grant_count", 32'(grants.size()), 32'd6);
        for (int i = 0; i < 6; i++) check("rr_order", 32'(grant_at(i)), 32'(exp_order[i]));
        check("rr_xfers", 32'(obs_xfer), 32'd6);

        // Four-flit packet holds the path while input 0 waits.
        do_reset();
        valid = 5'b00100; last = '0; rdy = '1; dst = '0;
        set_dst(2, 1); set_dst(0, 0);
        for (int c = 0; c < 14; c++) begin
            valid[0] = (c >= 1);
            last[0]  = 1'b1;
            valid[2] = (m_sent[2] < 4);
            last[2]  = (m_sent[2] == 3);
            step();
        end
        check("pkt4_first", 32'(grant_at(0)), 32'd2);
        check("pkt4_second", 32'(grant_at(1)), 32'd0);
        check("pkt4_flits", 32'(obs_xfer_in[2]), 32'd4);

        // Backpressure: output not ready for two cycles, then an input bubble.
        do_reset();
        valid = '0; last = '0; rdy = '1; dst = '0; set_dst(3, 2);
        for (int c = 0; c < 10; c++) begin
            n        = m_sent[3];
            valid[3] = (c != 4) && (n < 3);
            last[3]  = (n == 2);
            rdy[2]   = !(c == 2 || c == 3);
            step();
        end
        check("bp_xfers", 32'(obs_xfer), 32'd3);

        // Out-of-range destination on input 1 is never served.
        do_reset();
        valid = 5'b01010; last = '1; rdy = '1; dst = '0;
        set_dst(1, 6); set_dst(3, 0);
        repeat (10) step();
        check("oor_port1", 32'(obs_xfer_in[1]), 32'd0);
        check("oor_port3", 32'(obs_xfer_in[3]), 32'd5);

        // Reset during the second flit of a four-flit packet.
        do_reset();
        valid = 5'b00100; last = '0; rdy = '1; dst = '0; set_dst(2, 1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        grants.delete();
        valid = 5'b10001; last = '1; set_dst(0, 2); set_dst(4, 3);
        step();
        step();
        step();
        check("mid_rst_first", 32'(grant_at(0)), 32'd0);

        // Random traffic, including stray resets and out-of-range destinations.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 49) == 0);
            valid = N'($urandom);
            last  = N'($urandom);
            rdy   = N'($urandom | $urandom);
            for (int k = 0; k < N; k++) set_dst(k, int'($urandom_range(0, 7)));
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
